mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported backing memory between the CPU instruction-fetch port (I) and the data port (D).
- Sits between the cpu and the Memory model. Serialises accesses, drives the memory request handshake, and returns read data plus one-cycle done pulses.
- A watchdog aborts memory accesses that hang and flags an error.

Parameters:
- WORD_SIZE, 16, width of addresses and data words.
- TIMEOUT, 64, maximum ACCESS-state cycles waiting for m_ready before abort (1..255).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  instruction read request; held until i_done.
- i_addr  in  WORD_SIZE  instruction address.
- i_rdata  out  WORD_SIZE  registered instruction read data.
- i_done  out  1  one-cycle pulse: I access complete.
- i_busy  out  1  i_req & ~i_done (combinational stall for fetch).
- d_read  in  1  data read request; held until d_done.
- d_write  in  1  data write request; held until d_done.
- d_addr  in  WORD_SIZE  data address.
- d_wdata  in  WORD_SIZE  write data.
- d_rdata  out  WORD_SIZE  registered data read result.
- d_done  out  1  one-cycle pulse: D access complete.
- d_busy  out  1  (d_read|d_write) & ~d_done.
- m_read  out  1  memory read strobe, held through the access.
- m_write  out  1  memory write strobe, held through the access.
- m_addr  out  WORD_SIZE  latched access address.
- m_wdata  out  WORD_SIZE  latched write data.
- m_rdata  in  WORD_SIZE  memory read data, valid when m_ready=1.
- m_ready  in  1  memory completion, sampled at posedge.
- err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE. Outputs cleared: m_read, m_write, i_done, d_done and err to 0; m_addr, m_wdata, i_rdata and d_rdata to 0. Internal: wd_cnt=0, last_grant=I.
- Reset mid-access: strobes drop immediately and no done pulse is issued. The requester re-presents after reset deasserts.
- States: IDLE, ACCESS, RESP.
- IDLE, sampling at posedge:
  - Nothing pending: stay in IDLE.
  - Only I pending: grant I.
  - Only D pending: grant D.
  - Both pending: grant per arbitration policy (Optional Feature).
  - On grant: latch address, op and write data into m_*; assert m_read or m_write; record the granted port; wd_cnt=0; go to ACCESS. The strobe is visible the cycle after the request is sampled.
- D op rule: d_read and d_write both high are treated as a write.
- I access: always a read.
- ACCESS, each posedge:
  - If m_ready=1: capture m_rdata into the granted port's rdata (reads only; a write leaves d_rdata unchanged). Drop strobes, go to RESP.
  - Else if wd_cnt==TIMEOUT-1: drop strobes. Load 16'hFFFF into the granted rdata for reads. Go to RESP with error flagged.
  - Else wd_cnt+1.
  - m_ready on the same edge as the timeout: m_ready wins, no error.
- RESP (exactly one cycle):
  - Pulse the granted port's done; pulse err if flagged.
  - Update last_grant.
  - Requests are not sampled. Return to IDLE.
- Minimum access is 3 cycles (IDLE grant, one ACCESS cycle with m_ready=1, RESP) plus memory wait cycles.
- Requesters change or deassert requests at the edge where done is seen.
- m_addr and m_wdata hold their values outside ACCESS until the next grant.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: round-robin on simultaneous I and D requests. Grant the port opposite to last_grant; a sole requester is always granted.
- Undefined: fixed priority, D always wins ties; last_grant is still maintained but unused.
- Both modes: first tie after reset goes to D.

Test Plan:
- Reset then i_req=1, i_addr=0x0010; memory returns 0xA5A5 with m_ready after 2 wait cycles:
  - m_read=1 and m_addr=0x0010 from cycle 1.
  - i_done pulses at cycle 4 with i_rdata=0xA5A5.
  - i_busy=1 until then; err=0.
- d_write=1, d_addr=0x0020, d_wdata=0x1234, m_ready immediate:
  - m_write=1 for one cycle, m_wdata=0x1234.
  - d_done pulses; d_rdata unchanged (0x0000).
- i_req and d_read held together for two back-to-back accesses:
  - Without ARB_RR_EN: D is served first, then I.
  - With ARB_RR_EN and four consecutive tie rounds: grants go D,I,D,I.
- d_read=1 at 0x0030 with m_ready never asserted, TIMEOUT=64:
  - Strobes drop after 64 ACCESS cycles.
  - d_done and err pulse together; d_rdata=0xFFFF.
  - A subsequent I request is served normally.
- reset asserted 1 cycle into an I ACCESS:
  - m_read falls to 0 before the next posedge; no i_done.
  - After release, a re-presented i_req completes normally.
- m_ready=1 on the exact cycle wd_cnt reaches TIMEOUT-1:
  - Data is captured from m_rdata; err=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the CPU I-fetch and D ports onto one single-ported memory, with a
// watchdog abort. Define ARB_RR_EN for round-robin ties; default is D priority.
module mem_port_arbiter #(
   parameter int WORD_SIZE = 16,
   parameter int TIMEOUT   = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_req,
   input  logic [WORD_SIZE-1:0] i_addr,
   output logic [WORD_SIZE-1:0] i_rdata,
   output logic                 i_done,
   output logic                 i_busy,
   input  logic                 d_read,
   input  logic                 d_write,
   input  logic [WORD_SIZE-1:0] d_addr,
   input  logic [WORD_SIZE-1:0] d_wdata,
   output logic [WORD_SIZE-1:0] d_rdata,
   output logic                 d_done,
   output logic                 d_busy,
   output logic                 m_read,
   output logic                 m_write,
   output logic [WORD_SIZE-1:0] m_addr,
   output logic [WORD_SIZE-1:0] m_wdata,
   input  logic [WORD_SIZE-1:0] m_rdata,
   input  logic                 m_ready,
   output logic                 err
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

   state_t     state, state_nx;
   logic       grant_d;     // owner of the current access, 1 = D port
   logic       last_grant;  // owner of the previous completed access, 1 = D port
   logic [7:0] wd_cnt;

   logic d_pend;
   logic any_req;
   logic tie_d;
   logic pick_d;
   logic wd_expire;
   logic acc_end;

   assign d_pend  = d_read | d_write;
   assign any_req = i_req | d_pend;
   assign i_busy  = i_req & ~i_done;
   assign d_busy  = d_pend & ~d_done;

`ifdef ARB_RR_EN
   assign tie_d = ~last_grant;
`else
   // Fixed priority: D wins every tie; last_grant still tracks history but cannot change the result.
   assign tie_d = 1'b1 | last_grant;
`endif

   assign pick_d    = d_pend & (~i_req | tie_d);
   assign wd_expire = (wd_cnt == WD_LAST);
   assign acc_end   = m_ready | wd_expire;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (any_req) state_nx = ACCESS;
         ACCESS:  if (acc_end) state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_read     <= 1'b0;
         m_write    <= 1'b0;
         m_addr     <= '0;
         m_wdata    <= '0;
         i_rdata    <= '0;
         d_rdata    <= '0;
         i_done     <= 1'b0;
         d_done     <= 1'b0;
         err        <= 1'b0;
         grant_d    <= 1'b0;
         last_grant <= 1'b0;
         wd_cnt     <= 8'd0;
      end else begin
         i_done <= 1'b0;
         d_done <= 1'b0;
         err    <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant_d <= pick_d;
                  wd_cnt  <= 8'd0;
                  if (pick_d) begin
                     // A simultaneous read+write request is served as a write.
                     m_addr  <= d_addr;
                     m_wdata <= d_wdata;
                     m_write <= d_write;
                     m_read  <= ~d_write;
                  end else begin
                     m_addr  <= i_addr;
                     m_write <= 1'b0;
                     m_read  <= 1'b1;
                  end
               end
            end
            ACCESS: begin
               if (acc_end) begin
                  m_read  <= 1'b0;
                  m_write <= 1'b0;
                  // m_ready takes precedence over an expiry on the same edge.
                  err     <= ~m_ready;
                  if (grant_d) d_done <= 1'b1;
                  else         i_done <= 1'b1;
                  if (!m_write) begin
                     if (grant_d) d_rdata <= m_ready ? m_rdata : '1;
                     else         i_rdata <= m_ready ? m_rdata : '1;
                  end
               end else begin
                  wd_cnt <= wd_cnt + 8'd1;
               end
            end
            RESP: begin
               last_grant <= grant_d;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single accesses, ties, watchdog abort and reset mid-access.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req, d_read, d_write, m_ready;
   logic [15:0] i_addr, d_addr, d_wdata, m_rdata;
   logic [15:0] i_rdata, d_rdata, m_addr, m_wdata;
   logic        i_done, i_busy, d_done, d_busy, m_read, m_write, err;

   int n_checks = 0;
   int n_errs   = 0;

   mem_port_arbiter #(.WORD_SIZE(16), .TIMEOUT(64)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_busy(i_busy),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done), .d_busy(d_busy),
      .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_ready(m_ready), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   logic [15:0] exp_addr [4];

   initial begin
      reset = 1'b1;
      i_req = 0; d_read = 0; d_write = 0; m_ready = 0;
      i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
      #1;
      check("rst_m_read", m_read, 0);
      check("rst_m_addr", m_addr, 0);
      check("rst_err", err, 0);
      do_reset();
      check("rst_i_rdata", i_rdata, 0);
      check("rst_d_rdata", d_rdata, 0);

      // I read with two memory wait cycles
      i_req = 1; i_addr = 16'h0010;
      tick();
      check("i_m_read_c1", m_read, 1);
      check("i_m_addr_c1", m_addr, 16'h0010);
      check("i_busy_c1", i_busy, 1);
      tick();
      tick();
      check("i_done_early", i_done, 0);
      check("i_busy_c3", i_busy, 1);
      m_ready = 1; m_rdata = 16'hA5A5;
      tick();
      check("i_done_c4", i_done, 1);
      check("i_rdata_c4", i_rdata, 16'hA5A5);
      check("i_err_c4", err, 0);
      check("i_m_read_off", m_read, 0);
      check("i_busy_c4", i_busy, 0);
      i_req = 0; m_ready = 0;
      tick();
      check("i_done_pulse", i_done, 0);

      // D write, immediate ready
      d_write = 1; d_addr = 16'h0020; d_wdata = 16'h1234; m_ready = 1; m_rdata = 16'hDEAD;
      tick();
      check("w_m_write", m_write, 1);
      check("w_m_read", m_read, 0);
      check("w_m_wdata", m_wdata, 16'h1234);
      check("w_m_addr", m_addr, 16'h0020);
      tick();
      check("w_m_write_off", m_write, 0);
      check("w_d_done", d_done, 1);
      check("w_d_rdata", d_rdata, 16'h0000);
      d_write = 0; m_ready = 0;
      tick();
      check("w_hold_addr", m_addr, 16'h0020);

      // read+write together is a write
      d_read = 1; d_write = 1; d_addr = 16'h0022; d_wdata = 16'h4321; m_ready = 1;
      tick();
      check("rw_m_write", m_write, 1);
      check("rw_m_read", m_read, 0);
      tick();
      check("rw_d_done", d_done, 1);
      d_read = 0; d_write = 0; m_ready = 0;
      tick();

      // four tie rounds right after reset
      do_reset();
`ifdef ARB_RR_EN
      exp_addr = '{16'h0200, 16'h0100, 16'h0200, 16'h0100};
`else
      exp_addr = '{16'h0200, 16'h0200, 16'h0200, 16'h0200};
`endif
      i_req = 1; d_read = 1; i_addr = 16'h0100; d_addr = 16'h0200; m_ready = 1;
      for (int r = 0; r < 4; r++) begin
         m_rdata = 16'hC000 + 16'(r);
         tick();
         check($sformatf("tie%0d_addr", r), m_addr, exp_addr[r]);
         tick();
         check($sformatf("tie%0d_d_done", r), d_done, (exp_addr[r] == 16'h0200) ? 1 : 0);
         check($sformatf("tie%0d_i_done", r), i_done, (exp_addr[r] == 16'h0100) ? 1 : 0);
         if (exp_addr[r] == 16'h0200) check($sformatf("tie%0d_d_rdata", r), d_rdata, 16'hC000 + 16'(r));
         else                         check($sformatf("tie%0d_i_rdata", r), i_rdata, 16'hC000 + 16'(r));
         tick();
      end
      d_read = 0; m_rdata = 16'h0BB0;
      tick();
      check("tie_i_after_addr", m_addr, 16'h0100);
      tick();
      check("tie_i_after_done", i_done, 1);
      check("tie_i_after_rdata", i_rdata, 16'h0BB0);
      i_req = 0; m_ready = 0;
      tick();

      // watchdog abort on a D read
      d_read = 1; d_addr = 16'h0030; m_rdata = 16'h1111;
      tick();
      check("to_m_read_start", m_read, 1);
      for (int k = 0; k < 63; k++) tick();
      check("to_m_read_last", m_read, 1);
      check("to_no_done_yet", d_done, 0);
      tick();
      check("to_m_read_off", m_read, 0);
      check("to_d_done", d_done, 1);
      check("to_err", err, 1);
      check("to_d_rdata", d_rdata, 16'hFFFF);
      d_read = 0;
      tick();
      check("to_err_pulse", err, 0);
      i_req = 1; i_addr = 16'h0040; m_ready = 1; m_rdata = 16'h5A5A;
      tick();
      check("to_i_m_read", m_read, 1);
      tick();
      check("to_i_done", i_done, 1);
      check("to_i_rdata", i_rdata, 16'h5A5A);
      check("to_i_err", err, 0);
      i_req = 0; m_ready = 0;
      tick();

      // reset one cycle into an I access
      i_req = 1; i_addr = 16'h0050;
      tick();
      check("mr_m_read", m_read, 1);
      tick();
      reset = 1'b1;
      #1;
      check("mr_m_read_drop", m_read, 0);
      tick();
      check("mr_no_done", i_done, 0);
      reset = 1'b0; m_ready = 1; m_rdata = 16'h7777;
      tick();
      check("mr_re_m_read", m_read, 1);
      check("mr_re_m_addr", m_addr, 16'h0050);
      tick();
      check("mr_re_done", i_done, 1);
      check("mr_re_rdata", i_rdata, 16'h7777);
      i_req = 0; m_ready = 0;
      tick();

      // m_ready on the expiry edge wins
      d_read = 1; d_addr = 16'h0060;
      tick();
      for (int k = 0; k < 63; k++) tick();
      m_ready = 1; m_rdata = 16'hBEEF;
      tick();
      check("edge_d_done", d_done, 1);
      check("edge_err", err, 0);
      check("edge_d_rdata", d_rdata, 16'hBEEF);
      d_read = 0; m_ready = 0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
